// File: rtl/zcip_array_sched.sv
// Group scheduler for the ZCIP lane array: admits one index group at a time,
// restarts the array, and buffers its shift-offset beats in a FIFO for downstream.
module zcip_array_sched #(
  parameter int LANES   = 32,
  parameter int IDX_W   = 7,
  parameter int OFF_W   = 3,
  parameter int MAX_RUN = 8,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IDX_W-1:0]   in_index,
  output logic                     arr_rst,
  output logic [LANES*IDX_W-1:0]   arr_index_vector,
  input  logic [LANES*OFF_W-1:0]   arr_shift_offset,
  input  logic [LANES-1:0]         arr_valid,
  input  logic [LANES-1:0]         arr_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OFF_W-1:0]   out_shift_offset,
  output logic [LANES-1:0]         out_lane_mask,
  output logic                     out_last,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [15:0]              group_cnt
);

  localparam int BEAT_W = LANES*OFF_W + LANES + 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int RUN_W  = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [RUN_W-1:0]   run_cnt;
  logic [BEAT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   free_cnt;
  logic [BEAT_W-1:0]  push_data;
  logic [BEAT_W-1:0]  head;
  logic               push;
  logic               pop;
  logic               load;
  logic               all_done;
  logic               run_inc;
  logic               finish;
  logic               timeout_hit;

  assign all_done  = &arr_done;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop this cycle frees its slot before the admitted group can push.
  assign free_cnt  = CNT_W'(DEPTH) - count + {{(CNT_W-1){1'b0}}, pop};

  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    load        = 1'b0;
    push        = 1'b0;
    push_data   = '0;
    run_inc     = 1'b0;
    finish      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst && (free_cnt >= CNT_W'(MAX_RUN));
        if (in_valid && in_ready) begin
          load       = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = RUN;
      end
      RUN: begin
        if (|arr_valid || all_done) begin
          push      = 1'b1;
          push_data = {arr_shift_offset, arr_valid, all_done};
        end
        if (all_done) begin
          finish     = 1'b1;
          next_state = IDLE;
        end else if (run_cnt == RUN_W'(MAX_RUN-1)) begin
          // The timeout marker takes this cycle's single FIFO slot.
          push        = 1'b1;
          push_data   = {{(BEAT_W-1){1'b0}}, 1'b1};
          finish      = 1'b1;
          timeout_hit = 1'b1;
          next_state  = IDLE;
        end else begin
          run_inc = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      run_cnt          <= '0;
      arr_index_vector <= '0;
      group_cnt        <= '0;
      timeout_err      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == LOAD) begin
        run_cnt <= '0;
      end else if (run_inc) begin
        run_cnt <= run_cnt + 1'b1;
      end
      if (load) begin
        arr_index_vector <= in_index;
      end
      if (finish) begin
        group_cnt <= group_cnt + 16'd1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the head outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head             = mem[rd_ptr];
  assign out_shift_offset = out_valid ? head[BEAT_W-1 -: LANES*OFF_W] : '0;
  assign out_lane_mask    = out_valid ? head[LANES:1] : '0;
  assign out_last         = out_valid & head[0];
  assign arr_rst          = rst | (state == LOAD);
  assign busy             = (state != IDLE) | out_valid;

endmodule

// File: tb/tb_zcip_array_sched.sv
// Randomized bench for zcip_array_sched: a scripted array stub feeds each group,
// and a beat scoreboard built from the group scripts checks the FIFO output.
module tb_zcip_array_sched;

  localparam int LANES   = 32;
  localparam int IDX_W   = 7;
  localparam int OFF_W   = 3;
  localparam int MAX_RUN = 8;
  localparam int DEPTH   = 16;
  localparam int IW      = LANES*IDX_W;
  localparam int OW      = LANES*OFF_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IW-1:0]   in_index = '0;
  logic            arr_rst;
  logic [IW-1:0]   arr_index_vector;
  logic [OW-1:0]   arr_shift_offset = '0;
  logic [LANES-1:0] arr_valid = '0;
  logic [LANES-1:0] arr_done = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OW-1:0]   out_shift_offset;
  logic [LANES-1:0] out_lane_mask;
  logic            out_last;
  logic            busy;
  logic            timeout_err;
  logic [15:0]     group_cnt;

  always #5 clk = ~clk;

  zcip_array_sched #(
    .LANES(LANES), .IDX_W(IDX_W), .OFF_W(OFF_W), .MAX_RUN(MAX_RUN), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
    .arr_rst(arr_rst), .arr_index_vector(arr_index_vector),
    .arr_shift_offset(arr_shift_offset), .arr_valid(arr_valid), .arr_done(arr_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_shift_offset(out_shift_offset), .out_lane_mask(out_lane_mask), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err), .group_cnt(group_cnt)
  );

  // A group script: which RUN cycle reports all-done (-1 = never) and what
  // the lanes present on each RUN cycle.
  typedef struct packed {
    int                               done_at;
    logic [MAX_RUN-1:0][LANES-1:0]    valid;
    logic [MAX_RUN-1:0][OW-1:0]       off;
  } script_t;

  typedef struct packed {
    logic [OW-1:0]    off;
    logic [LANES-1:0] mask;
    logic             last;
  } beat_t;

  script_t scripts[$];
  beat_t   expq[$];
  script_t pending;
  script_t cur;

  int total = 0;
  int bad = 0;
  int exp_groups = 0;
  logic exp_timeout = 1'b0;
  logic [IW-1:0] last_index = '0;

  logic drv_rst = 1'b1;
  logic drv_in_valid = 1'b0;
  logic [IW-1:0] drv_in_index = '0;
  logic drv_out_ready = 1'b0;
  logic rand_ready = 1'b0;

  logic stub_active = 1'b0;
  int   stub_k = 0;
  logic acc_d1 = 1'b0;
  logic acc_d2 = 1'b0;
  logic accepted = 1'b0;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 random, 1 three full beats, 2 zero group, 3 never done, 4 slow group
  function automatic script_t gen_script(input int kind);
    script_t s;
    int d;
    for (int k = 0; k < MAX_RUN; k++) begin
      s.off[k]   = {$urandom, $urandom, $urandom};
      s.valid[k] = ($urandom_range(0, 1) == 1) ? LANES'($urandom) : '0;
    end
    case (kind)
      1: begin
        s.done_at = 2;
        for (int k = 0; k < MAX_RUN; k++) s.valid[k] = (k <= 2) ? '1 : '0;
      end
      2: begin
        s.done_at = 0;
        s.valid   = '0;
      end
      3: begin
        s.done_at = -1;
        s.valid[MAX_RUN-1] = '0;
      end
      4: begin
        s.done_at = 5;
        s.valid   = '0;
        s.valid[0] = '1;
      end
      default: begin
        d = $urandom_range(0, MAX_RUN);
        s.done_at = (d == MAX_RUN) ? -1 : d;
        if (s.done_at < 0) s.valid[MAX_RUN-1] = '0;
      end
    endcase
    return s;
  endfunction

  // Beats a group must produce, derived straight from its script.
  function automatic void expect_beats(input script_t s);
    beat_t b;
    for (int k = 0; k < MAX_RUN; k++) begin
      if (k == s.done_at) begin
        b.off = s.off[k]; b.mask = s.valid[k]; b.last = 1'b1;
        expq.push_back(b);
        break;
      end else if (k == MAX_RUN-1) begin
        b.off = '0; b.mask = '0; b.last = 1'b1;
        expq.push_back(b);
      end else if (s.valid[k] != '0) begin
        b.off = s.off[k]; b.mask = s.valid[k]; b.last = 1'b0;
        expq.push_back(b);
      end
    end
  endfunction

  task automatic step();
    beat_t b;
    logic [LANES-1:0] d;
    @(negedge clk);
    if (rand_ready) drv_out_ready = ($urandom_range(0, 3) != 0);
    rst       = drv_rst;
    in_valid  = drv_in_valid;
    in_index  = drv_in_index;
    out_ready = drv_out_ready;
    #1;
    checkOutput("arr_rst", arr_rst, drv_rst || acc_d1);
    if (acc_d1 || acc_d2) checkOutput("in_ready_busy", in_ready, 0);

    if (acc_d2) begin
      cur = scripts.pop_front();
      stub_active = 1'b1;
      stub_k = 0;
    end
    if (stub_active) begin
      d = LANES'($urandom);
      d[$urandom_range(0, LANES-1)] = 1'b0;
      arr_done         = (stub_k == cur.done_at) ? '1 : d;
      arr_valid        = cur.valid[stub_k];
      arr_shift_offset = cur.off[stub_k];
      if (stub_k == cur.done_at || stub_k == MAX_RUN-1) stub_active = 1'b0;
      else stub_k++;
    end else begin
      arr_done         = LANES'($urandom);
      arr_valid        = LANES'($urandom);
      arr_shift_offset = {$urandom, $urandom, $urandom};
    end

    if (!drv_rst && dut.push && !(out_valid && drv_out_ready) && dut.count == DEPTH)
      checkOutput("fifo_overflow", 1, 0);

    if (out_valid && drv_out_ready && !drv_rst) begin
      if (expq.size() == 0) begin
        checkOutput("spurious_beat", 1, 0);
      end else begin
        b = expq.pop_front();
        checkOutput("beat_off", out_shift_offset, b.off);
        checkOutput("beat_mask", out_lane_mask, b.mask);
        checkOutput("beat_last", out_last, b.last);
      end
    end

    accepted = drv_in_valid && in_ready && !drv_rst;
    if (accepted) begin
      scripts.push_back(pending);
      expect_beats(pending);
      exp_groups++;
      if (pending.done_at < 0) exp_timeout = 1'b1;
      last_index = drv_in_index;
    end
    acc_d2 = acc_d1;
    acc_d1 = accepted;

    if (drv_rst) begin
      scripts.delete();
      expq.delete();
      stub_active = 1'b0;
      acc_d1 = 1'b0;
      acc_d2 = 1'b0;
      exp_groups = 0;
      exp_timeout = 1'b0;
      last_index = '0;
    end
  endtask

  task automatic applyStimulus(input int kind, input bit use_pattern, input int bound, output bit ok);
    logic [IW-1:0] idx;
    logic [IW-1:0] pat;
    pat = {28{8'h55}};
    for (int i = 0; i < IW/32; i++) idx[i*32 +: 32] = $urandom;
    pending      = gen_script(kind);
    drv_in_index = use_pattern ? pat : idx;
    drv_in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      ok = accepted;
    end
    drv_in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    rand_ready = 1'b0;
    drv_out_ready = 1'b1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (expq.size() == 0 && scripts.size() == 0 && !stub_active && !acc_d1 && !acc_d2) break;
    end
    step();
    checkOutput("drain_left", expq.size(), 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_out_valid", out_valid, 0);
    checkOutput("group_cnt", group_cnt, exp_groups[15:0]);
    checkOutput("timeout_err", timeout_err, exp_timeout);
  endtask

  initial begin
    bit ok;
    int n;
    logic [IW-1:0] pat;
    pat = {28{8'h55}};

    drv_rst = 1'b1;
    step();
    step();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_group_cnt", group_cnt, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_index", arr_index_vector, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_mask", out_lane_mask, 0);
    drv_rst = 1'b0;
    step();
    checkOutput("idle_in_ready", in_ready, 1);

    $display("[TB] basic group");
    drv_out_ready = 1'b1;
    applyStimulus(1, 1'b1, 10, ok);
    checkOutput("basic_accept", ok, 1);
    drain(40);
    checkOutput("basic_index", arr_index_vector, pat);
    checkOutput("basic_groups", group_cnt, 1);

    $display("[TB] zero group");
    applyStimulus(2, 1'b0, 10, ok);
    checkOutput("zero_accept", ok, 1);
    step();
    checkOutput("zero_ready_t1", in_ready, 0);
    step();
    checkOutput("zero_ready_t2", in_ready, 0);
    step();
    checkOutput("zero_ready_t3", in_ready, 1);
    drain(40);
    checkOutput("zero_index", arr_index_vector, last_index);

    $display("[TB] backpressure");
    drv_out_ready = 1'b0;
    n = 0;
    for (int g = 0; g < 4; g++) begin
      applyStimulus(1, 1'b0, 20, ok);
      if (ok) n++;
    end
    checkOutput("bp_groups", n, 3);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_busy", busy, 1);
    drain(60);

    $display("[TB] timeout");
    applyStimulus(3, 1'b0, 10, ok);
    checkOutput("to_accept", ok, 1);
    drain(60);
    checkOutput("to_flag", timeout_err, 1);
    applyStimulus(1, 1'b0, 10, ok);
    drain(60);
    checkOutput("to_sticky", timeout_err, 1);

    $display("[TB] reset mid-run");
    drv_out_ready = 1'b0;
    applyStimulus(2, 1'b0, 10, ok);
    step();
    step();
    step();
    applyStimulus(4, 1'b0, 10, ok);
    checkOutput("mr_accept", ok, 1);
    step();
    step();
    drv_rst = 1'b1;
    step();
    checkOutput("mr_buffered", out_valid, 1);
    drv_rst = 1'b0;
    step();
    checkOutput("mr_out_valid", out_valid, 0);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_group_cnt", group_cnt, 0);
    checkOutput("mr_timeout", timeout_err, 0);
    checkOutput("mr_in_ready", in_ready, 1);

    $display("[TB] random traffic");
    rand_ready = 1'b1;
    for (int g = 0; g < 60; g++) begin
      applyStimulus(0, 1'b0, 60, ok);
      checkOutput("rand_accept", ok, 1);
    end
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/zcip_array_sched.md
Name: zcip_array_sched

Overview:
Group scheduler for the 32-lane ZCIP array.
- Accepts one 32-lane group of 7-bit index vectors per handshake and restarts the array for that group.
- Holds the indices stable while the lanes run, and collects per-cycle shift-offset beats until every lane reports done.
- Buffers the beats in an internal FIFO so downstream backpressure never loses an array output; the ZCIP array has no stall input.
- Sits between the weight/index fetch stage and the shift-accumulate datapath.

Parameters:
LANES, 32, number of ZCIP lanes
IDX_W, 7, index-vector width per lane
OFF_W, 3, shift-offset width per lane
MAX_RUN, 8, maximum RUN cycles per group before timeout
DEPTH, 16, beat FIFO depth (power of 2, must be >= MAX_RUN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  group available
in_ready  output  1  group accepted when in_valid&in_ready
in_index  input  LANES*IDX_W  lane i at [i*7+6:i*7]
arr_rst  output  1  reset to ZCIP array (= rst OR load pulse)
arr_index_vector  output  LANES*IDX_W  registered indices to array
arr_shift_offset  input  LANES*OFF_W  array shift offsets
arr_valid  input  LANES  per-lane offset valid
arr_done  input  LANES  per-lane done
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
out_shift_offset  output  LANES*OFF_W  beat offsets
out_lane_mask  output  LANES  lanes whose offset is valid in this beat
out_last  output  1  final beat of the group
busy  output  1  state != IDLE or FIFO non-empty
timeout_err  output  1  sticky timeout flag, cleared only by rst
group_cnt  output  16  groups completed, wraps at 2^16

Behaviour:
Reset:
- State IDLE; FIFO empty.
- All outputs 0 except arr_rst, which is 1 while rst is high.
- arr_index_vector is 0; timeout_err is 0; group_cnt is 0.

FSM states: IDLE, LOAD, RUN.
- IDLE:
  - in_ready = 1 iff free FIFO entries >= MAX_RUN; this also accounts for a pop in the same cycle.
  - On handshake: register in_index into arr_index_vector and go to LOAD.
- LOAD (exactly 1 cycle):
  - arr_rst = 1; run counter cleared; next state RUN.
- RUN (arr_rst = 0):
  - Each cycle, all_done = &arr_done.
  - If |arr_valid or all_done: push beat {arr_shift_offset, arr_valid, all_done}. out_lane_mask = arr_valid; lanes not valid keep their raw offset bits; downstream must ignore them.
  - If all_done: group_cnt += 1; go to IDLE. An all-zero group therefore produces one beat with mask 0 and last = 1.
  - Else if run counter == MAX_RUN-1: push {0, 0, last = 1}; set timeout_err; group_cnt += 1; go to IDLE.
  - Else: run counter += 1.
- in_ready = 0 in LOAD and RUN.
- arr_index_vector holds its value until the next accepted group.

Timing:
- Handshake in cycle t.
- arr_rst is high in t+1.
- First RUN sample in t+2.
- A beat pushed in cycle c is visible on out_* in c+1.
- Minimum group period is 3 cycles (IDLE→LOAD→RUN with all_done in the first RUN cycle).

FIFO:
- Registered head; out_valid = !empty.
- Push and pop in the same cycle are legal: count unchanged, including when full or empty+push.
- Overflow cannot occur because of the admission rule. A push when full is a design error; the bench asserts it never happens.
- Pointers wrap modulo DEPTH.
- out_* stay stable while out_valid & !out_ready.

Reset mid-operation:
- Any state returns to IDLE within the reset cycle.
- FIFO is flushed; in-flight beats are discarded.
- arr_rst is high for the whole reset.

Test Plan:
- Stub array: all lanes done 3 cycles after arr_rst falls, arr_valid=all-ones on RUN cycles 0–2. Send in_index = 0x55.. pattern, with out_ready=1 → arr_rst pulses 1 cycle; 3 beats with mask 0xFFFFFFFF; 3rd beat out_last=1; group_cnt=1; arr_index_vector equals the sent pattern.
- Zero group: stub asserts &arr_done in RUN cycle 0 with arr_valid=0 → exactly one beat with mask 0 and out_last=1; next in_ready at t+3.
- Backpressure: out_ready=0, DEPTH=16, MAX_RUN=8, groups of 3 beats each:
  - In IDLE, in_ready is 1 only while the FIFO holds ≤8 beats; issue groups back-to-back until it drops.
  - After 3 groups (9 beats) in_ready=0.
  - Releasing out_ready yields 9 beats in order with no loss or duplication.
- Timeout: stub never asserts arr_done → after 8 RUN cycles, one beat {0,0,last=1}; timeout_err=1 and stays 1 across later good groups until rst.
- Reset mid-RUN: assert rst during RUN cycle 1 with 2 beats buffered → next cycle out_valid=0, state IDLE, group_cnt=0, arr_rst=1 during rst.
- Simultaneous push/pop with FIFO full-1 and out_ready=1 for 20 cycles → count constant; beat order preserved; group_cnt increments by number of out_last beats.
